// File: rtl/bus_pkg.sv
// Shared bus definitions: default widths and the slave FSM encoding used by
// master, arbiter and slave endpoints.
package bus_pkg;

    localparam int BUS_ADDR_W = 14;
    localparam int BUS_DATA_W = 8;
    localparam int BUS_ID_W   = 2;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        RX_ADDR  = 3'd1,
        WRITE    = 3'd2,
        RD_WAIT  = 3'd3,
        RD_VALID = 3'd4,
        RD_TX    = 3'd5
    } slave_state_t;

endpackage

// File: rtl/slave_mem.sv
// Single-port synchronous RAM with a READ_LAT-deep registered read path.
module slave_mem #(
    parameter int AW       = 12,
    parameter int DW       = 8,
    parameter int READ_LAT = 1
) (
    input  logic          clock,
    input  logic          we,
    input  logic [AW-1:0] addr,
    input  logic [DW-1:0] wdata,
    output logic [DW-1:0] rdata
);

    logic [DW-1:0] mem [0:(1<<AW)-1];
    logic [DW-1:0] rd_pipe [READ_LAT];

    always_ff @(posedge clock) begin
        if (we) begin
            mem[addr] <= wdata;
        end
        rd_pipe[0] <= mem[addr];
        for (int i = 1; i < READ_LAT; i++) begin
            rd_pipe[i] <= rd_pipe[i-1];
        end
    end

    assign rdata = rd_pipe[READ_LAT-1];

endmodule

// File: rtl/bus_slave_port.sv
// Serial-bus slave endpoint: deserialises address/write data, decodes the
// slave ID, writes the local RAM and serialises read data back to the master.
module bus_slave_port
    import bus_pkg::*;
#(
    parameter int                ADDR_W   = BUS_ADDR_W,
    parameter int                DATA_W   = BUS_DATA_W,
    parameter int                ID_W     = BUS_ID_W,
    parameter logic [ID_W-1:0]   SLAVE_ID = '0,
    parameter int                MEM_AW   = ADDR_W - ID_W,
    parameter int                READ_LAT = 1
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         valid,
    input  logic         mode,
    input  logic         addr_rx,
    input  logic         data_rx,
    output logic         data_tx,
    output logic         slave_valid,
    output logic         slave_ready,
    output logic         busy,
    output slave_state_t state_dbg
);

    localparam int CNT_W = $clog2(ADDR_W + 1);
    localparam int LAT_W = 2;

    slave_state_t state, next_state;

    logic              mode_q;
    logic [CNT_W-1:0]  bit_cnt;
    logic [LAT_W-1:0]  lat_cnt;
    logic [ADDR_W-2:0] addr_sr;
    logic [DATA_W-1:0] data_sr;
    logic [DATA_W-1:0] tx_sr;
    logic [DATA_W-1:0] mem_rdata;
    logic [ADDR_W-1:0] addr_full;
    logic              last_bit;
    logic              id_match;
    logic              mem_we;

    // Full address including the bit arriving this cycle, so the decode
    // happens on the same edge that samples the last address bit.
    assign addr_full = {addr_sr, addr_rx};
    assign last_bit  = (bit_cnt == CNT_W'(ADDR_W - 1));
    assign id_match  = (addr_full[ADDR_W-1 -: ID_W] == SLAVE_ID);
    assign mem_we    = (state == WRITE) && !reset;

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (valid) next_state = RX_ADDR;
            end
            RX_ADDR: begin
                if (last_bit) begin
                    if (!id_match)  next_state = IDLE;
                    else if (mode_q) next_state = RD_WAIT;
                    else             next_state = WRITE;
                end
            end
            WRITE:    next_state = IDLE;
            RD_WAIT: begin
                if (lat_cnt == LAT_W'(READ_LAT - 1)) next_state = RD_VALID;
            end
            RD_VALID: next_state = RD_TX;
            RD_TX: begin
                if (bit_cnt == CNT_W'(DATA_W - 1)) next_state = IDLE;
            end
            default:  next_state = IDLE;
        endcase
    end

    always_comb begin
        slave_ready = (state == IDLE);
        busy        = (state != IDLE);
        slave_valid = (state == RD_VALID);
        data_tx     = (state == RD_TX) ? tx_sr[DATA_W-1] : 1'b0;
        state_dbg   = state;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            mode_q  <= 1'b0;
            bit_cnt <= '0;
            lat_cnt <= '0;
            addr_sr <= '0;
            data_sr <= '0;
            tx_sr   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (valid) begin
                        mode_q  <= mode;
                        bit_cnt <= '0;
                    end
                end
                RX_ADDR: begin
                    addr_sr <= addr_full[ADDR_W-2:0];
                    if (bit_cnt >= CNT_W'(ADDR_W - DATA_W)) begin
                        data_sr <= {data_sr[DATA_W-2:0], data_rx};
                    end
                    bit_cnt <= last_bit ? '0 : bit_cnt + 1'b1;
                    lat_cnt <= '0;
                end
                RD_WAIT: lat_cnt <= lat_cnt + 1'b1;
                // Pipeline output is valid by the end of RD_VALID for any READ_LAT.
                RD_VALID: begin
                    tx_sr   <= mem_rdata;
                    bit_cnt <= '0;
                end
                RD_TX: begin
                    tx_sr   <= {tx_sr[DATA_W-2:0], 1'b0};
                    bit_cnt <= bit_cnt + 1'b1;
                end
                default: ;
            endcase
        end
    end

    slave_mem #(
        .AW       (MEM_AW),
        .DW       (DATA_W),
        .READ_LAT (READ_LAT)
    ) u_mem (
        .clock (clock),
        .we    (mem_we),
        .addr  (addr_sr[MEM_AW-1:0]),
        .wdata (data_sr),
        .rdata (mem_rdata)
    );

endmodule

// File: tb/tb_bus_slave_port.sv
// Bench for bus_slave_port: three endpoints (READ_LAT 1..3) share one serial
// stimulus stream; read bytes are scored against a RAM model via exp_q.
module tb_bus_slave_port;
    import bus_pkg::*;

    localparam int AW = 14;
    localparam int DW = 8;

    logic clock = 1'b0;
    logic reset = 1'b1;
    logic valid = 1'b0;
    logic mode = 1'b0;
    logic addr_rx = 1'b0;
    logic data_rx = 1'b0;
    logic [2:0] dtx, sv, rdy, bsy;
    slave_state_t st [3];

    for (genvar g = 0; g < 3; g++) begin : g_dut
        bus_slave_port #(.READ_LAT(g + 1)) dut (
            .clock       (clock),
            .reset       (reset),
            .valid       (valid),
            .mode        (mode),
            .addr_rx     (addr_rx),
            .data_rx     (data_rx),
            .data_tx     (dtx[g]),
            .slave_valid (sv[g]),
            .slave_ready (rdy[g]),
            .busy        (bsy[g]),
            .state_dbg   (st[g])
        );
    end

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    int total = 0;
    int bad = 0;
    logic [DW-1:0] exp_q [$];
    logic [DW-1:0] model [0:4095];

    // Drives one transaction; k returns the edge count at which valid was sampled.
    task automatic send(input logic m, input logic [AW-1:0] a, input logic [DW-1:0] d,
                        input int glitch_bit, input int reset_bit, output int k);
        valid = 1'b1;
        mode  = m;
        @(posedge clock); #1;
        k = cyc;
        for (int i = AW - 1; i >= 0; i--) begin
            addr_rx = a[i];
            data_rx = (i < DW) ? d[3'(i)] : 1'b0;
            valid   = (i == glitch_bit);
            mode    = (i == glitch_bit);
            reset   = (i == reset_bit);
            @(posedge clock); #1;
            if (i == reset_bit) begin
                reset = 1'b0;
                total++;
                if (rdy !== 3'b111 || bsy !== 3'b000 || sv !== 3'b000 || dtx !== 3'b000 || st[0] !== IDLE) begin
                    bad++;
                    $display("FAIL reset_mid: ready=%b busy=%b valid=%b tx=%b state=%0d, want ready=111 busy=000 valid=000 tx=000 state=0",
                             rdy, bsy, sv, dtx, st[0]);
                end
            end
        end
        valid = 1'b0; mode = 1'b0; reset = 1'b0; addr_rx = 1'b0; data_rx = 1'b0;
    endtask

    task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d, input int glitch_bit, input int reset_bit);
        int k;
        send(1'b0, a, d, glitch_bit, reset_bit, k);
        if (reset_bit < 0 && a[AW-1 -: 2] == 2'd0) model[a[11:0]] = d;
        @(posedge clock); #1;
    endtask

    task automatic do_read(input logic [AW-1:0] a, input string name);
        int k;
        int vc [3], vcyc [3], nb [3], rcyc [3], stray [3];
        logic [DW-1:0] by [3];
        logic [DW-1:0] expv;
        exp_q.push_back(model[a[11:0]]);
        send(1'b1, a, 8'h00, -1, -1, k);
        for (int d = 0; d < 3; d++) begin
            vc[d] = 0; vcyc[d] = -100; nb[d] = 0; rcyc[d] = -1; stray[d] = 0; by[d] = '0;
        end
        for (int n = 0; n < 16; n++) begin
            @(negedge clock);
            for (int d = 0; d < 3; d++) begin
                if (sv[d]) begin
                    vc[d]++;
                    if (vc[d] == 1) vcyc[d] = cyc;
                end
                if (vc[d] > 0 && cyc > vcyc[d] && nb[d] < DW) begin
                    by[d] = {by[d][DW-2:0], dtx[d]};
                    nb[d]++;
                end else if (dtx[d]) begin
                    stray[d]++;
                end
                if (vc[d] > 0 && cyc > vcyc[d] && rdy[d] && rcyc[d] < 0) rcyc[d] = cyc;
            end
        end
        expv = exp_q.pop_front();
        for (int d = 0; d < 3; d++) begin
            // slave_valid is sampled high at edge k+AW+RL+1, i.e. seen on the negedge before it.
            total++;
            if (vc[d] != 1 || vcyc[d] != k + AW + d + 1) begin
                bad++;
                $display("FAIL %s valid_timing rl=%0d: pulses=%0d at=%0d, want pulses=1 at=%0d", name, d + 1, vc[d], vcyc[d], k + AW + d + 1);
            end
            total++;
            if (by[d] !== expv || nb[d] != DW) begin
                bad++;
                $display("FAIL %s data rl=%0d: got %h (%0d bits), want %h", name, d + 1, by[d], nb[d], expv);
            end
            total++;
            if (rcyc[d] != vcyc[d] + DW + 1) begin
                bad++;
                $display("FAIL %s ready_rise rl=%0d: at=%0d, want %0d", name, d + 1, rcyc[d], vcyc[d] + DW + 1);
            end
            total++;
            if (stray[d] != 0) begin
                bad++;
                $display("FAIL %s tx_idle rl=%0d: stray ones=%0d, want 0", name, d + 1, stray[d]);
            end
        end
    endtask

    task automatic test_reset;
        reset = 1'b1;
        repeat (2) @(posedge clock);
        #1;
        total++;
        if (rdy !== 3'b111 || bsy !== 3'b000 || sv !== 3'b000 || dtx !== 3'b000 || st[0] !== IDLE) begin
            bad++;
            $display("FAIL reset: ready=%b busy=%b valid=%b tx=%b state=%0d, want 111 000 000 000 0", rdy, bsy, sv, dtx, st[0]);
        end
        reset = 1'b0;
        @(posedge clock); #1;
    endtask

    task automatic test_write_read;
        do_write(14'h0000, 8'h00, -1, -1);
        do_write(14'h00A5, 8'h3C, -1, -1);
        do_read(14'h00A5, "wr_rd_a5");
    endtask

    task automatic test_non_match;
        int k;
        int hits;
        do_write(14'h0123, 8'h00, -1, -1);
        send(1'b0, 14'h1000, 8'hFF, -1, -1, k);
        @(negedge clock);
        total++;
        if (cyc != k + AW || rdy !== 3'b111 || st[0] !== IDLE) begin
            bad++;
            $display("FAIL non_match_idle: cyc=%0d ready=%b state=%0d, want cyc=%0d ready=111 state=0", cyc, rdy, st[0], k + AW);
        end
        hits = 0;
        for (int n = 0; n < 12; n++) begin
            @(negedge clock);
            if (sv !== 3'b000 || dtx !== 3'b000) hits++;
        end
        total++;
        if (hits != 0) begin
            bad++;
            $display("FAIL non_match_quiet: active cycles=%0d, want 0", hits);
        end
        @(posedge clock); #1;
        do_read(14'h0000, "non_match_ram");
    endtask

    task automatic test_read_latency;
        do_write(14'h0FFF, 8'h81, -1, -1);
        do_read(14'h0FFF, "lat_fff");
    endtask

    task automatic test_busy_restart;
        do_write(14'h0010, 8'h5A, 5, -1);
        do_read(14'h0010, "restart_ignored");
    endtask

    task automatic test_reset_mid;
        do_write(14'h0020, 8'h99, -1, -1);
        do_write(14'h0020, 8'h77, -1, 10);
        do_read(14'h0020, "reset_discard");
        do_write(14'h0020, 8'h12, -1, -1);
        do_read(14'h0020, "after_reset");
    endtask

    task automatic test_back_to_back;
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        for (int n = 0; n < 3; n++) begin
            a = {2'b00, 12'($urandom_range(0, 4095))};
            d = 8'($urandom_range(0, 255));
            do_write(a, d, -1, -1);
            do_read(a, "back_to_back");
        end
    endtask

    initial begin
        test_reset;
        test_write_read;
        test_non_match;
        test_read_latency;
        test_busy_restart;
        test_reset_mid;
        test_back_to_back;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
